// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 memory-access stage.
// Holds the access FSM state encoding and the doubleword alignment mask.
package legv8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  function automatic logic is_misaligned(input logic [2:0] addr_lo);
    return (addr_lo & ALIGN_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/memory_access_flopenr.sv
// flopenr: parameterised enable flop with asynchronous active-low reset.
// Used as the EX/MEM pipeline register of memory_access.
module flopenr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Pipeline register: cleared on reset, loads only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_access.sv
// LEGv8 memory-access stage: EX/MEM register, data-memory handshake FSM, branch redirect.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (traps non-doubleword-aligned accesses).
module memory_access
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         valid_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         branch_E,
  input  logic         regWrite_E,
  input  logic         memtoReg_E,
  input  logic [4:0]   rd_E,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [4:0]   rd_M,
  output logic         regWrite_M,
  output logic         memtoReg_M,
  output logic         valid_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         misalign_M
);

  localparam int W = 3 * N + 12;

  logic [W-1:0] exmem_d_s;
  logic [W-1:0] exmem_q_s;

  logic [N-1:0] alu_result_r;
  logic [N-1:0] write_data_r;
  logic [N-1:0] pc_branch_r;
  logic         zero_r;
  logic         valid_r;
  logic         mem_read_r;
  logic         mem_write_r;
  logic         branch_r;
  logic         reg_write_r;
  logic         memto_reg_r;
  logic [4:0]   rd_r;

  mem_state_t   state_r;
  mem_state_t   state_next_s;
  logic         memop_s;
  logic         misalign_s;
  logic         req_s;
  logic         stall_s;
  logic [N-1:0] read_data_r;

  assign exmem_d_s = {aluResult_E, writeData_E, PCBranch_E, zero_E, valid_E, memRead_E,
                      memWrite_E, branch_E, regWrite_E, memtoReg_E, rd_E};

  flopenr #(.W(W)) u_exmem (
    .clk   (clk),
    .rst_n (reset),
    .en    (~stall_s),
    .d     (exmem_d_s),
    .q     (exmem_q_s)
  );

  assign {alu_result_r, write_data_r, pc_branch_r, zero_r, valid_r, mem_read_r,
          mem_write_r, branch_r, reg_write_r, memto_reg_r, rd_r} = exmem_q_s;

  assign memop_s = valid_r & (mem_read_r | mem_write_r);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_s = memop_s & is_misaligned(alu_result_r[2:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // A trapped misaligned access still stalls for its IDLE cycle, but never requests memory
  assign stall_s = memop_s & (state_r != DONE);
  assign req_s   = stall_s & ~misalign_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; dm_ack only matters while a request is outstanding
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (memop_s & misalign_s) begin
          state_next_s = DONE;
        end else if (memop_s & dm_ack) begin
          state_next_s = DONE;
        end else if (memop_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (dm_ack) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Load data captured on the acknowledge cycle of a read request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_r <= {N{1'b0}};
    end else if (req_s & dm_ack & mem_read_r) begin
      read_data_r <= dm_rdata;
    end
  end

  assign dm_req   = req_s;
  assign dm_we    = mem_write_r;
  assign dm_addr  = alu_result_r;
  assign dm_wdata = write_data_r;

  assign stall_M     = stall_s;
  assign valid_M     = valid_r & (~memop_s | (state_r == DONE));
  assign misalign_M  = misalign_s & (state_r == DONE);
  assign regWrite_M  = reg_write_r & valid_M & ~misalign_s;
  assign rd_M        = rd_r;
  assign memtoReg_M  = memto_reg_r;
  assign aluResult_M = alu_result_r;
  assign readData_M  = read_data_r;
  assign PCSrc_M     = branch_r & zero_r & valid_r;
  assign PCBranch_M  = pc_branch_r;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access.
// Build with MEM_MISALIGN_CHECK_EN defined to exercise the misalignment trap.
module tb_memory_access;
  import legv8_pkg::*;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         zero_E, valid_E, memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E;
  logic [4:0]   rd_E;
  logic         stall_M, PCSrc_M, regWrite_M, memtoReg_M, valid_M;
  logic [N-1:0] PCBranch_M, aluResult_M, readData_M;
  logic [4:0]   rd_M;
  logic         dm_req, dm_we, dm_ack, misalign_M;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;

  int checks = 0;
  int errors = 0;

  memory_access #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .valid_E(valid_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .branch_E(branch_E), .regWrite_E(regWrite_E), .memtoReg_E(memtoReg_E), .rd_E(rd_E),
    .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
    .aluResult_M(aluResult_M), .readData_M(readData_M), .rd_M(rd_M),
    .regWrite_M(regWrite_M), .memtoReg_M(memtoReg_M), .valid_M(valid_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .misalign_M(misalign_M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    aluResult_E = 64'h0; writeData_E = 64'h0; PCBranch_E = 64'h0;
    zero_E = 1'b0; valid_E = 1'b0; memRead_E = 1'b0; memWrite_E = 1'b0;
    branch_E = 1'b0; regWrite_E = 1'b0; memtoReg_E = 1'b0; rd_E = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    dm_ack = 1'b1;
    dm_rdata = 64'h0;
    bubble();

    // Reset state
    #12;
    check("rst_dm_req", 64'(dm_req), 64'd0);
    check("rst_stall", 64'(stall_M), 64'd0);
    check("rst_valid", 64'(valid_M), 64'd0);
    check("rst_pcsrc", 64'(PCSrc_M), 64'd0);
    check("rst_regwrite", 64'(regWrite_M), 64'd0);
    check("rst_misalign", 64'(misalign_M), 64'd0);
    check("rst_readdata", readData_M, 64'h0);
    dm_ack = 1'b0;

    // ADD on the first edge after release
    reset = 1'b1;
    valid_E = 1'b1; aluResult_E = 64'h10; regWrite_E = 1'b1; rd_E = 5'd3;
    tick();
    check("add_alu", aluResult_M, 64'h10);
    check("add_valid", 64'(valid_M), 64'd1);
    check("add_stall", 64'(stall_M), 64'd0);
    check("add_dm_req", 64'(dm_req), 64'd0);
    check("add_regwrite", 64'(regWrite_M), 64'd1);
    check("add_rd", 64'(rd_M), 64'd3);
    bubble();

    // LDUR 0x40, ack on third request cycle
    tick();
    valid_E = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h40; regWrite_E = 1'b1;
    memtoReg_E = 1'b1; rd_E = 5'd5;
    tick();
    bubble();
    check("ld_c1_stall", 64'(stall_M), 64'd1);
    check("ld_c1_req", 64'(dm_req), 64'd1);
    check("ld_addr", dm_addr, 64'h40);
    check("ld_we", 64'(dm_we), 64'd0);
    check("ld_c1_valid", 64'(valid_M), 64'd0);
    tick();
    check("ld_c2_stall", 64'(stall_M), 64'd1);
    check("ld_c2_state", 64'(dut.state_r), 64'(WAIT));
    tick();
    dm_ack = 1'b1; dm_rdata = 64'hDEAD;
    #1;
    check("ld_c3_stall", 64'(stall_M), 64'd1);
    check("ld_c3_req", 64'(dm_req), 64'd1);
    tick();
    dm_ack = 1'b0; dm_rdata = 64'h0;
    check("ld_done_state", 64'(dut.state_r), 64'(DONE));
    check("ld_done_stall", 64'(stall_M), 64'd0);
    check("ld_done_req", 64'(dm_req), 64'd0);
    check("ld_rdata", readData_M, 64'hDEAD);
    check("ld_valid", 64'(valid_M), 64'd1);
    check("ld_regwrite", 64'(regWrite_M), 64'd1);
    check("ld_memtoreg", 64'(memtoReg_M), 64'd1);
    tick();
    check("ld_after_state", 64'(dut.state_r), 64'(IDLE));
    check("ld_rdata_hold", readData_M, 64'hDEAD);

    // STUR with same-cycle ack
    valid_E = 1'b1; memWrite_E = 1'b1; aluResult_E = 64'h48; writeData_E = 64'h1234;
    dm_ack = 1'b1;
    tick();
    bubble();
    check("st_req", 64'(dm_req), 64'd1);
    check("st_we", 64'(dm_we), 64'd1);
    check("st_wdata", dm_wdata, 64'h1234);
    check("st_c1_stall", 64'(stall_M), 64'd1);
    tick();
    dm_ack = 1'b0;
    check("st_done_stall", 64'(stall_M), 64'd0);
    check("st_done_valid", 64'(valid_M), 64'd1);
    check("st_regwrite", 64'(regWrite_M), 64'd0);
    check("st_rdata_hold", readData_M, 64'hDEAD);
    tick();

    // CBZ taken / not taken / invalid slot
    valid_E = 1'b1; branch_E = 1'b1; zero_E = 1'b1; PCBranch_E = 64'h80;
    tick();
    check("cbz_pcsrc", 64'(PCSrc_M), 64'd1);
    check("cbz_target", PCBranch_M, 64'h80);
    zero_E = 1'b0;
    tick();
    check("cbz_nt_pcsrc", 64'(PCSrc_M), 64'd0);
    zero_E = 1'b1; valid_E = 1'b0;
    tick();
    check("cbz_inv_pcsrc", 64'(PCSrc_M), 64'd0);
    bubble();

    // Reset while in WAIT
    valid_E = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h50; regWrite_E = 1'b1;
    tick();
    bubble();
    tick();
    check("rw_state", 64'(dut.state_r), 64'(WAIT));
    check("rw_stall", 64'(stall_M), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rw_req_drop", 64'(dm_req), 64'd0);
    check("rw_stall_drop", 64'(stall_M), 64'd0);
    check("rw_valid", 64'(valid_M), 64'd0);
    check("rw_rdata_clr", readData_M, 64'h0);
    #2;
    reset = 1'b1;
    #1;
    check("rw_state_idle", 64'(dut.state_r), 64'(IDLE));
    valid_E = 1'b1; aluResult_E = 64'h20; regWrite_E = 1'b1;
    tick();
    check("rw_accept", aluResult_M, 64'h20);
    check("rw_accept_valid", 64'(valid_M), 64'd1);
    bubble();
    tick();

    // LDUR at misaligned address 0x43
    valid_E = 1'b1; memRead_E = 1'b1; aluResult_E = 64'h43; regWrite_E = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
    dm_ack = 1'b1;
    tick();
    bubble();
    check("mis_req", 64'(dm_req), 64'd0);
    check("mis_c1_flag", 64'(misalign_M), 64'd0);
    tick();
    dm_ack = 1'b0;
    check("mis_state", 64'(dut.state_r), 64'(DONE));
    check("mis_flag", 64'(misalign_M), 64'd1);
    check("mis_regwrite", 64'(regWrite_M), 64'd0);
    check("mis_done_req", 64'(dm_req), 64'd0);
    tick();
    check("mis_flag_clear", 64'(misalign_M), 64'd0);
`else
    dm_ack = 1'b1; dm_rdata = 64'hBEEF;
    tick();
    bubble();
    check("mis_off_req", 64'(dm_req), 64'd1);
    check("mis_off_addr", dm_addr, 64'h43);
    tick();
    dm_ack = 1'b0;
    check("mis_off_flag", 64'(misalign_M), 64'd0);
    check("mis_off_rdata", readData_M, 64'hBEEF);
    check("mis_off_regwrite", 64'(regWrite_M), 64'd1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
